// File: rtl/display_scan_mux_pkg.sv
// Shared types and helpers for the display scan multiplexer.
package display_scan_mux_pkg;

  // Scan controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Level of an output bit when it is not driving anything
  function automatic logic inactive_level(input int active_low);
    return (active_low != 0);
  endfunction

  // Larger of two durations, used to size the shared slot timer
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_scan_mux_slot_timer.sv
// Down-counting slot timer shared by the blank guard and the show slot.
// done is high once the loaded count has run out.
module display_scan_mux_slot_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  // Counter: clear wins over load, otherwise count down to zero and stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed segment/digit driver: scans CHANNELS segment words onto a
// shared bus with blank guard slots between channels, auto or manual select.
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int WIDTH        = 7,
  parameter int CHANNELS     = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          mode,
  input  logic [$clog2(CHANNELS)-1:0]   sel_manual,
  input  logic [CHANNELS*WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]              seg_out,
  output logic [CHANNELS-1:0]           dig_en,
  output logic                          frame_tick
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(max2(DIV, BLANK_CYCLES) + 1);

  // Timer reload values: the timer reports done after (value) further cycles
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(DIV - 1);

  // Inactive bus levels; XOR with these applies the output polarity
  localparam logic [WIDTH-1:0]    SEG_IDLE = {WIDTH{inactive_level(ACTIVE_LOW)}};
  localparam logic [CHANNELS-1:0] DIG_IDLE = {CHANNELS{inactive_level(ACTIVE_LOW)}};

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CH_W-1:0]     ch_next;
  logic                tmr_clr, tmr_load, tmr_done;
  logic [CNT_W-1:0]    tmr_val;
  logic [WIDTH-1:0]    seg_d;
  logic [CHANNELS-1:0] dig_d;
  logic                tick_d;
  logic [WIDTH-1:0]    word_sel;
  logic [CHANNELS-1:0] onehot_sel;

  display_scan_mux_slot_timer #(
    .CNT_W(CNT_W)
  ) u_slot_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Current channel's word and digit, plus the channel that follows this slot
  always_comb begin
    word_sel   = data_in[ch_q*WIDTH +: WIDTH];
    onehot_sel = {{(CHANNELS-1){1'b0}}, 1'b1} << ch_q;
    if (mode) begin
      // Out-of-range manual selections fall back to channel 0
      ch_next = (int'(sel_manual) >= CHANNELS) ? '0 : sel_manual;
    end else begin
      ch_next = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
    end
  end

  // Next-state and next-output logic; outputs default to the inactive level
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    seg_d    = SEG_IDLE;
    dig_d    = DIG_IDLE;
    tick_d   = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      ch_d    = '0;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_BLANK;
          ch_d     = '0;
          tmr_load = 1'b1;
          tmr_val  = BLANK_LOAD;
        end
        ST_BLANK: begin
          if (tmr_done) begin
            state_d  = ST_SHOW;
            tmr_load = 1'b1;
            tmr_val  = SHOW_LOAD;
            // Word is captured once here; later data_in changes wait for the next slot
            seg_d    = word_sel ^ SEG_IDLE;
            dig_d    = onehot_sel ^ DIG_IDLE;
            tick_d   = (ch_q == '0) && !mode;
          end
        end
        ST_SHOW: begin
          if (tmr_done) begin
            state_d  = ST_BLANK;
            tmr_load = 1'b1;
            tmr_val  = BLANK_LOAD;
            ch_d     = ch_next;
          end else begin
            seg_d = seg_out;
            dig_d = dig_en;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ch_d    = '0;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  // State, channel index and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      seg_out    <= SEG_IDLE;
      dig_en     <= DIG_IDLE;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      seg_out    <= seg_d;
      dig_en     <= dig_d;
      frame_tick <= tick_d;
    end
  end

endmodule
